bcd_stream_converter: RTL

- KPN process node placed downstream of subtractor_module. It replaces the free-running binary-to-BCD path that feeds write_to_display.
- Pops one 16-bit binary token from its input FIFO and converts it to packed BCD with a sequential double-dabble FSM, one bit per cycle.
- Pushes the BCD token into an output FIFO that the display stage drains.
- Uses the same rd/wr token handshake as adder_module and subtractor_module, plus FIFO empty/full flow control.

---
 rtl/bcd_stream_converter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bcd_stream_converter.sv
// KPN node: pops a binary token, converts it to packed BCD by sequential double dabble, pushes the result.
// Optional build macro BCD_SIGNED_INPUT_EN: two's-complement input, magnitude converted, sign on sign_out.
module bcd_stream_converter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  empty_in,
   input  logic [WIDTH-1:0]      entry_1,
   output logic                  rd,
   input  logic                  full_out,
   output logic                  wr,
   output logic [4*DIGITS-1:0]   output_1,
`ifdef BCD_SIGNED_INPUT_EN
   output logic                  sign_out,
`endif
   output logic                  busy
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WRITE} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   bin_sr;
   logic [BCD_W-1:0]   bcd_acc;
   logic [BCD_W-1:0]   bcd_adj;
   logic [BCD_W-1:0]   bcd_next;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   load_val;

   function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

`ifdef BCD_SIGNED_INPUT_EN
   logic sign_pend;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
   endfunction

   // The most negative value wraps to itself, which read as unsigned is the right magnitude.
   assign load_val = magnitude(entry_1);
`else
   assign load_val = entry_1;
`endif

   assign bcd_adj  = add3_nibbles(bcd_acc);
   assign bcd_next = BCD_W'({bcd_adj, bin_sr[WIDTH-1]});
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // rd is combinational from IDLE so the upstream FIFO data lands exactly in LOAD.
   always_comb begin
      state_nxt = state;
      rd        = 1'b0;
      wr        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty_in) begin
               rd        = !rst;
               state_nxt = LOAD;
            end
         end
         LOAD:  state_nxt = SHIFT;
         SHIFT: if (cnt == '0) state_nxt = WRITE;
         WRITE: begin
            if (!full_out) begin
               wr        = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The result register is loaded on the last shift so it is already valid while wr is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_sr    <= '0;
         bcd_acc   <= '0;
         cnt       <= '0;
         output_1  <= '0;
`ifdef BCD_SIGNED_INPUT_EN
         sign_pend <= 1'b0;
         sign_out  <= 1'b0;
`endif
      end else begin
         case (state)
            LOAD: begin
               bin_sr    <= load_val;
               bcd_acc   <= '0;
               cnt       <= CNT_W'(WIDTH - 1);
`ifdef BCD_SIGNED_INPUT_EN
               sign_pend <= entry_1[WIDTH-1];
`endif
            end
            SHIFT: begin
               bcd_acc <= bcd_next;
               bin_sr  <= {bin_sr[WIDTH-2:0], 1'b0};
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  output_1 <= bcd_next;
`ifdef BCD_SIGNED_INPUT_EN
                  sign_out <= sign_pend;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
